fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the write port of one synchronous FIFO among N_REQ producers. It selects one requester per cycle and registers that requester's word onto the FIFO write port. The FIFO's almostfull flag is used to avoid overflowing the FIFO while a write is in flight. The FIFO's wr_ack/overflow response is routed back to the requester that issued the write.

---
 rtl/fifo_wr_arbiter_if.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the shared FIFO write port.
// master = arbiter, slave = producers plus FIFO.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 16
);
  logic                          en;
  logic [N_REQ-1:0]              req;
  logic [N_REQ*DATA_WIDTH-1:0]   req_data;
  logic [N_REQ-1:0]              gnt;
  logic [N_REQ-1:0]              done;
  logic [N_REQ-1:0]              err;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;
  logic                          busy;
  logic [1:0]                    arb_state;

  modport master (
    input  en, req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    output gnt, done, err, fifo_wr_en, fifo_data_in, busy, arb_state
  );

  modport slave (
    output en, req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    input  gnt, done, err, fifo_wr_en, fifo_data_in, busy, arb_state
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N_REQ producers.
// Optional macro FIFO_ARB_HIPRI_EN: requester 0 becomes strict high priority.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | no pending request or arbitration disabled
// ST_RUN   | a grant was issued last cycle
// ST_STALL | requests pending but blocked by FIFO flags
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic                  fifo_wr_en_q, fifo_wr_en_d;
  logic [DATA_WIDTH-1:0] fifo_data_in_q, fifo_data_in_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       cur_id_q, cur_id_d;
  logic                  trk_vld_q, trk_vld_d;
  logic [ID_W-1:0]       trk_id_q, trk_id_d;

  logic                  issue;
  logic                  found;
  logic [ID_W-1:0]       sel;
  logic [DATA_WIDTH-1:0] sel_data;
  int                    idx;

  // Blocking a write while the previous one sits on the port and the FIFO has one slot left.
  assign issue = rst_n && bus.en && (|bus.req) && !bus.fifo_full
                 && !(bus.fifo_almostfull && fifo_wr_en_q);

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
`ifdef FIFO_ARB_HIPRI_EN
    if (bus.req[0]) begin
      found = 1'b1;
    end
`endif
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req[idx]) begin
        sel   = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    bus.gnt  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel == ID_W'(i)) begin
        sel_data   = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        bus.gnt[i] = issue;
      end
    end
  end

  always_comb begin
    fifo_wr_en_d   = issue;
    fifo_data_in_d = fifo_data_in_q;
    cur_id_d       = cur_id_q;
    rr_ptr_d       = rr_ptr_q;
    trk_vld_d      = fifo_wr_en_q;
    trk_id_d       = cur_id_q;
    if (issue) begin
      fifo_data_in_d = sel_data;
      cur_id_d       = sel;
      rr_ptr_d       = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
`ifdef FIFO_ARB_HIPRI_EN
      if (sel == '0) rr_ptr_d = rr_ptr_q;
`endif
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (issue) begin
      state_d = ST_RUN;
    end else if (bus.en && (|bus.req)) begin
      state_d = ST_STALL;
    end
  end

  always_comb begin
    bus.done = '0;
    bus.err  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (trk_id_q == ID_W'(i)) begin
        bus.done[i] = trk_vld_q && bus.fifo_wr_ack;
        bus.err[i]  = trk_vld_q && (bus.fifo_overflow || !bus.fifo_wr_ack);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      fifo_wr_en_q   <= 1'b0;
      fifo_data_in_q <= '0;
      rr_ptr_q       <= '0;
      cur_id_q       <= '0;
      trk_vld_q      <= 1'b0;
      trk_id_q       <= '0;
    end else begin
      state_q        <= state_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_data_in_q <= fifo_data_in_d;
      rr_ptr_q       <= rr_ptr_d;
      cur_id_q       <= cur_id_d;
      trk_vld_q      <= trk_vld_d;
      trk_id_q       <= trk_id_d;
    end
  end

  assign bus.fifo_wr_en   = fifo_wr_en_q;
  assign bus.fifo_data_in = fifo_data_in_q;
  assign bus.busy         = fifo_wr_en_q || trk_vld_q;
  assign bus.arb_state    = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a transaction-level reference model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fifo_wr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a two-slot pipeline of write ids; [1] = on the FIFO port, [0] = awaiting response.
  int              pend[$];
  int              m_rr;
  int              m_state;
  logic [DW-1:0]   m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend    = '{-1, -1};
    m_rr    = 0;
    m_state = 0;
    m_data  = '0;
  endtask

  task automatic step(input logic r, input logic e, input logic [N-1:0] rq,
                      input logic [N*DW-1:0] d, input logic f, input logic af,
                      input logic ack, input logic ovf);
    bit            iss;
    int            sel;
    int            tracked;
    logic [N-1:0]  exp_gnt, exp_done, exp_err;
    @(negedge clk);
    rst_n               = r;
    bus.en              = e;
    bus.req             = rq;
    bus.req_data        = d;
    bus.fifo_full       = f;
    bus.fifo_almostfull = af;
    bus.fifo_wr_ack     = ack;
    bus.fifo_overflow   = ovf;
    #1;
    iss = r && e && (rq != '0) && !f && !(af && pend[1] >= 0);
    sel = -1;
`ifdef FIFO_ARB_HIPRI_EN
    if (rq[0]) sel = 0;
`endif
    for (int i = 0; i < N; i++)
      if (sel < 0 && rq[(m_rr + i) % N]) sel = (m_rr + i) % N;
    exp_gnt  = iss ? N'(1) << sel : '0;
    tracked  = pend[0];
    exp_done = (tracked >= 0 && ack) ? N'(1) << tracked : '0;
    exp_err  = (tracked >= 0 && (ovf || !ack)) ? N'(1) << tracked : '0;
    check("gnt",       32'(bus.gnt),          32'(exp_gnt));
    check("done",      32'(bus.done),         32'(exp_done));
    check("err",       32'(bus.err),          32'(exp_err));
    check("wr_en",     32'(bus.fifo_wr_en),   32'(pend[1] >= 0));
    check("data_in",   32'(bus.fifo_data_in), 32'(m_data));
    check("busy",      32'(bus.busy),         32'(pend[0] >= 0 || pend[1] >= 0));
    check("arb_state", 32'(bus.arb_state),    32'(m_state));
    if (!r) begin
      model_reset();
    end else begin
      void'(pend.pop_front());
      pend.push_back(iss ? sel : -1);
      if (iss) begin
        m_data = d[sel*DW +: DW];
`ifdef FIFO_ARB_HIPRI_EN
        if (sel != 0) m_rr = (sel + 1) % N;
`else
        m_rr = (sel + 1) % N;
`endif
      end
      m_state = iss ? 1 : ((e && rq != '0) ? 2 : 0);
    end
  endtask

  function automatic logic [N*DW-1:0] rnd_words();
    logic [N*DW-1:0] w;
    for (int i = 0; i < N; i++) w[i*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  logic [N*DW-1:0] words;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.req = '0; bus.req_data = '0;
    bus.fifo_full = 1'b0; bus.fifo_almostfull = 1'b0;
    bus.fifo_wr_ack = 1'b0; bus.fifo_overflow = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // reset state, then all requesters with an empty FIFO
    step(0, 0, 4'b0000, '0, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) step(1, 1, 4'b1111, rnd_words(), 0, 0, 1, 0);

    // single requester with a fixed word
    words = rnd_words();
    words[2*DW +: DW] = 16'hA5A5;
    for (int c = 0; c < 6; c++) step(1, 1, 4'b0100, words, 0, 0, 1, 0);

    // almostfull while a write is on the port, then release
    step(1, 1, 4'b0100, words, 0, 1, 1, 0);
    step(1, 1, 4'b0100, words, 0, 0, 1, 0);
    step(1, 1, 4'b0100, words, 0, 0, 1, 0);

    // full held for 5 cycles
    for (int c = 0; c < 5; c++) step(1, 1, 4'b0011, words, 1, 0, 1, 0);
    for (int c = 0; c < 3; c++) step(1, 1, 4'b0011, words, 0, 0, 1, 0);

    // drain, then a single requester-1 write answered by overflow
    for (int c = 0; c < 3; c++) step(1, 1, 4'b0000, words, 0, 0, 1, 0);
    step(1, 1, 4'b0010, words, 0, 0, 1, 0);
    step(1, 1, 4'b0000, words, 0, 0, 1, 0);
    step(1, 1, 4'b0000, words, 0, 0, 0, 1);
    step(1, 1, 4'b0000, words, 0, 0, 1, 0);

    // en dropped mid-burst
    for (int c = 0; c < 3; c++) step(1, 1, 4'b1010, rnd_words(), 0, 0, 1, 0);
    for (int c = 0; c < 4; c++) step(1, 0, 4'b1010, rnd_words(), 0, 0, 1, 0);

    // reset between grant and response
    step(1, 1, 4'b0001, words, 0, 0, 1, 0);
    step(0, 1, 4'b0000, words, 0, 0, 1, 0);
    for (int c = 0; c < 3; c++) step(1, 1, 4'b0000, words, 0, 0, 1, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(63) != 0),
           ($urandom_range(7) != 0),
           N'($urandom),
           rnd_words(),
           ($urandom_range(7) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(3) != 0),
           ($urandom_range(7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
